imem_loader: RTL and testbench

Boot-time program loader and the write-side counterpart of the CPU's instruction fetch path. It receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them through a dedicated instruction-memory write port. The CPU core is held in reset until the image is fully written, then released so fetch starts at PC 0.

---
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_loader.sv | 184 ++++++++++++++++++
 tb/tb_imem_loader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream / instruction-memory write bundle for imem_loader.
// master: stream source and memory side; slave: the loader itself.
interface imem_loader_if;
    logic        START;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        RX_READY;
    logic        IMEM_WE;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IMEM_WDATA;
    logic        CPU_RST;
    logic        DONE;
    logic        ERR;

    modport master (
        output START, RX_DATA, RX_VALID,
        input  RX_READY, IMEM_WE, IMEM_ADDR, IMEM_WDATA, CPU_RST, DONE, ERR
    );

    modport slave (
        input  START, RX_DATA, RX_VALID,
        output RX_READY, IMEM_WE, IMEM_ADDR, IMEM_WDATA, CPU_RST, DONE, ERR
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed big-endian byte stream -> instruction-memory words,
// holds the CPU in reset until done. IMEM_LOADER_CHECKSUM_EN adds a trailing XOR byte.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic         CLK,
    input  logic         RST,
    imem_loader_if.slave bus
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_e;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e S_TAIL = S_CSUM;
`else
    localparam state_e S_TAIL = S_DONE;
`endif

    state_e      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [23:0] buf_q, buf_d;
    logic        ovf_q, ovf_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        cpu_rst_q, cpu_rst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic        rx_ready;
    logic        accept;
    logic        go;
    logic        fin;
    logic        load_bad;
    logic        in_range;
    logic [31:0] word_addr;

    assign rx_ready  = (state_q != S_DONE);
    assign accept    = bus.RX_VALID && rx_ready;
    // START only counts once DONE is visible, so a restart never skips the done report
    assign go        = (state_q == S_DONE) && done_q && bus.START;
    assign in_range  = (32'(idx_q) < 32'(MAX_WORDS));
    assign word_addr = BASE_ADDR + {14'h0, idx_q, 2'b00};

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign load_bad = ovf_q || (csum_q != 8'h00);
`else
    assign load_bad = ovf_q;
`endif

    // Flags are published one edge after reaching S_DONE, i.e. after the last write edge
    assign fin = (state_q == S_DONE) && !go;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        buf_d   = buf_q;
        ovf_d   = ovf_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = accept ? (csum_q ^ bus.RX_DATA) : csum_q;
`endif

        case (state_q)
            S_LEN_HI: begin
                if (accept) begin
                    len_d   = {8'h00, bus.RX_DATA};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d   = {len_q[7:0], bus.RX_DATA};
                    state_d = ({len_q[7:0], bus.RX_DATA} == 16'h0000) ? S_TAIL : S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    buf_d  = {buf_q[15:0], bus.RX_DATA};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        if (in_range) begin
                            we_d    = 1'b1;
                            addr_d  = word_addr;
                            wdata_d = {buf_q, bus.RX_DATA};
                        end else begin
                            ovf_d = 1'b1;
                        end
                        idx_d = idx_q + 16'd1;
                        if (idx_q == (len_q - 16'd1)) begin
                            state_d = S_TAIL;
                        end
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (go) begin
                    state_d = S_LEN_HI;
                    idx_d   = 16'h0000;
                    bcnt_d  = 2'd0;
                    ovf_d   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end
            end
            default: state_d = S_LEN_HI;
        endcase

        done_d    = fin;
        err_d     = fin && load_bad;
        cpu_rst_d = !(fin && !load_bad);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_LEN_HI;
            len_q     <= 16'h0000;
            idx_q     <= 16'h0000;
            bcnt_q    <= 2'd0;
            buf_q     <= 24'h000000;
            ovf_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0000_0000;
            wdata_q   <= 32'h0000_0000;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q    <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            bcnt_q    <= bcnt_d;
            buf_q     <= buf_d;
            ovf_q     <= ovf_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cpu_rst_q <= cpu_rst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign bus.RX_READY   = rx_ready;
    assign bus.IMEM_WE    = we_q;
    assign bus.IMEM_ADDR  = addr_q;
    assign bus.IMEM_WDATA = wdata_q;
    assign bus.DONE       = done_q;
    assign bus.ERR        = err_q;
    assign bus.CPU_RST    = cpu_rst_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, reset/restart sequences and
// randomized streams checked against a stream-parsing reference model.
module tb_imem_loader;

    localparam int unsigned MAXW = 2;
    localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_loader_if bus ();

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    logic [63:0] wr_q[$];
    int          b2b_cnt   = 0;
    int          early_cnt = 0;
    logic        prev_we   = 1'b0;
    logic [7:0]  stim[$];
    bit          noise_start = 1'b0;

    // Memory-side observer: captures each write at the edge the memory would
    always @(posedge clk) begin
        if (bus.IMEM_WE === 1'b1) begin
            wr_q.push_back({bus.IMEM_ADDR, bus.IMEM_WDATA});
            if (prev_we === 1'b1) b2b_cnt <= b2b_cnt + 1;
            if (bus.DONE !== 1'b0 || bus.CPU_RST !== 1'b1) early_cnt <= early_cnt + 1;
        end
        prev_we <= bus.IMEM_WE;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic build_stream(input int n, input logic [31:0] w[$], input bit corrupt);
        logic [15:0] n16;
        logic [7:0]  x;
        n16 = 16'(n);
        stim.delete();
        stim.push_back(n16[15:8]);
        stim.push_back(n16[7:0]);
        for (int i = 0; i < n; i++) begin
            stim.push_back(w[i][31:24]);
            stim.push_back(w[i][23:16]);
            stim.push_back(w[i][15:8]);
            stim.push_back(w[i][7:0]);
        end
        if (CSUM_ON) begin
            x = 8'h00;
            foreach (stim[i]) x = x ^ stim[i];
            stim.push_back(corrupt ? (x ^ 8'h5A) : x);
        end
    endtask

    // Reference: parse the stream as a whole and list the writes it should cause
    task automatic model(output logic [63:0] ew[$], output bit eerr);
        int          n;
        logic [31:0] word;
        logic [7:0]  x;
        ew.delete();
        n = int'({stim[0], stim[1]});
        for (int i = 0; i < n; i++) begin
            word = {stim[2+4*i], stim[3+4*i], stim[4+4*i], stim[5+4*i]};
            if (i < int'(MAXW)) ew.push_back({BASE + 32'(4*i), word});
        end
        eerr = (n > int'(MAXW));
        if (CSUM_ON) begin
            x = 8'h00;
            foreach (stim[i]) x = x ^ stim[i];
            if (x != 8'h00) eerr = 1'b1;
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge
    task automatic send_byte(input logic [7:0] b);
        int cnt;
        bus.RX_VALID = 1'b1;
        bus.RX_DATA  = b;
        cnt = 0;
        while (bus.RX_READY !== 1'b1 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 50) begin
            chk("rx_ready_timeout", 64'(bus.RX_READY), 64'h1);
            bus.RX_VALID = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.RX_VALID = 1'b0;
    endtask

    task automatic load(input int gap, output int nwr, output bit err_o, output bit crst_o);
        logic [63:0] ew[$];
        bit          eerr;
        int          b0, e0, lat, n;
        wr_q.delete();
        b0 = b2b_cnt;
        e0 = early_cnt;
        n  = int'({stim[0], stim[1]});
        foreach (stim[i]) begin
            send_byte(stim[i]);
            if (i != stim.size() - 1) begin
                repeat (gap) begin
                    if (noise_start) bus.START = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                bus.START = 1'b0;
            end
        end
        chk("done_early", 64'(bus.DONE), 64'h0);
        lat = 0;
        while (bus.DONE !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("done_seen", 64'(bus.DONE), 64'h1);
        if (n == 0) chk("n0_done_latency", 64'(lat), 64'h1);
        model(ew, eerr);
        chk("wr_count", 64'(wr_q.size()), 64'(ew.size()));
        for (int i = 0; i < ew.size() && i < wr_q.size(); i++)
            chk("wr_addr_data", wr_q[i], ew[i]);
        chk("wr_back_to_back", 64'(b2b_cnt - b0), 64'h0);
        chk("done_before_write", 64'(early_cnt - e0), 64'h0);
        chk("rx_ready_in_done", 64'(bus.RX_READY), 64'h0);
        chk("err_vs_model", 64'(bus.ERR), 64'(eerr));
        chk("cpu_rst_vs_model", 64'(bus.CPU_RST), 64'(eerr));
        nwr    = wr_q.size();
        err_o  = bus.ERR;
        crst_o = bus.CPU_RST;
    endtask

    // START pulse with a competing byte that must not be accepted
    task automatic do_start();
        bus.START    = 1'b1;
        bus.RX_VALID = 1'b1;
        bus.RX_DATA  = 8'hA5;
        @(negedge clk);
        bus.START    = 1'b0;
        bus.RX_VALID = 1'b0;
        chk("start_done", 64'(bus.DONE), 64'h0);
        chk("start_err", 64'(bus.ERR), 64'h0);
        chk("start_cpu_rst", 64'(bus.CPU_RST), 64'h1);
        chk("start_rx_ready", 64'(bus.RX_READY), 64'h1);
    endtask

    typedef struct {
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        int          gap;
        bit          corrupt;
        int          exp_nwr;
        bit          exp_err;
    } vec_t;

    initial begin
        vec_t        tbl[6];
        logic [31:0] wq[$];
        int          nwr;
        bit          e, c;

        tbl[0] = '{2, 32'h2008_0005, 32'hAC09_0004, 32'h0, 0, 1'b0, 2, 1'b0};
        tbl[1] = '{2, 32'h2008_0005, 32'hAC09_0004, 32'h0, 3, 1'b0, 2, 1'b0};
        tbl[2] = '{0, 32'h0, 32'h0, 32'h0, 0, 1'b0, 0, 1'b0};
        tbl[3] = '{3, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1, 1'b0, 2, 1'b1};
        tbl[4] = '{1, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 1'b1, 1, CSUM_ON};
        tbl[5] = '{2, 32'h0123_4567, 32'h89AB_CDEF, 32'h0, 2, 1'b0, 2, 1'b0};

        bus.START    = 1'b0;
        bus.RX_VALID = 1'b0;
        bus.RX_DATA  = 8'h00;

        @(negedge clk);
        chk("rst_we", 64'(bus.IMEM_WE), 64'h0);
        chk("rst_addr", 64'(bus.IMEM_ADDR), 64'h0);
        chk("rst_wdata", 64'(bus.IMEM_WDATA), 64'h0);
        chk("rst_done", 64'(bus.DONE), 64'h0);
        chk("rst_err", 64'(bus.ERR), 64'h0);
        chk("rst_cpu_rst", 64'(bus.CPU_RST), 64'h1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rx_ready", 64'(bus.RX_READY), 64'h1);

        for (int i = 0; i < 6; i++) begin
            if (bus.DONE === 1'b1) do_start();
            wq = '{tbl[i].w0, tbl[i].w1, tbl[i].w2};
            build_stream(tbl[i].n, wq, tbl[i].corrupt);
            load(tbl[i].gap, nwr, e, c);
            chk($sformatf("tbl%0d_nwr", i), 64'(nwr), 64'(tbl[i].exp_nwr));
            chk($sformatf("tbl%0d_err", i), 64'(e), 64'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_cpu_rst", i), 64'(c), 64'(tbl[i].exp_err));
            if (i == 0) begin
                chk("plan_w0", wr_q[0], {32'h0000_0000, 32'h2008_0005});
                chk("plan_w1", wr_q[1], {32'h0000_0004, 32'hAC09_0004});
            end
        end

        // Asynchronous reset in the middle of word 0
        do_start();
        stim = '{8'h00, 8'h01, 8'hDE, 8'hAD};
        foreach (stim[i]) send_byte(stim[i]);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_we", 64'(bus.IMEM_WE), 64'h0);
        chk("mid_rst_addr", 64'(bus.IMEM_ADDR), 64'h0);
        chk("mid_rst_wdata", 64'(bus.IMEM_WDATA), 64'h0);
        chk("mid_rst_done", 64'(bus.DONE), 64'h0);
        chk("mid_rst_err", 64'(bus.ERR), 64'h0);
        chk("mid_rst_cpu_rst", 64'(bus.CPU_RST), 64'h1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_rx_ready", 64'(bus.RX_READY), 64'h1);
        wq = '{32'hDEAD_BEEF};
        build_stream(1, wq, 1'b0);
        load(0, nwr, e, c);
        chk("post_rst_nwr", 64'(nwr), 64'h1);
        chk("post_rst_word", wr_q[0], {32'h0000_0000, 32'hDEAD_BEEF});
        chk("post_rst_cpu_rst", 64'(c), 64'h0);

        // Random streams, with stray START pulses while loading
        for (int r = 0; r < 12; r++) begin
            int n;
            n = int'($urandom_range(0, 4));
            wq.delete();
            for (int j = 0; j < n; j++) wq.push_back($urandom);
            if (bus.DONE === 1'b1) do_start();
            noise_start = 1'b1;
            build_stream(n, wq, ($urandom_range(0, 3) == 0));
            load(int'($urandom_range(0, 2)), nwr, e, c);
            noise_start = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
